// File: rtl/reaction_sequencer.sv
// Reaction-time trial sequencer: waits a clamped random delay, lights the stimulus,
// then times the button press in ms, flagging false starts and timeouts.
module reaction_sequencer #(
   parameter int TICKS_PER_MS = 100000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int MAX_DELAY_MS = 5000,
   parameter int TIMEOUT_MS   = 9999,
   parameter int W            = 14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         button,
   input  logic [W-1:0] rnd_in,
   output logic         rng_enable,
   output logic         stim_led,
   output logic [W-1:0] rt_ms,
   output logic         rt_valid,
   output logic         false_start,
   output logic         timeout,
   output logic         busy
);

   localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
   localparam logic [W-1:0]  MIN_D      = W'(MIN_DELAY_MS);
   localparam logic [W-1:0]  MAX_D      = W'(MAX_DELAY_MS);
   localparam logic [W-1:0]  TIMEOUT_V  = W'(TIMEOUT_MS);

   typedef enum logic [2:0] {IDLE, WAIT, REACT, DONE, FAULT} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] prescaler, prescaler_nxt, prescaler_adv;
   logic [W-1:0]  delay_cnt, delay_cnt_nxt;
   logic [W-1:0]  rt_cnt, rt_cnt_nxt, rt_inc;
   logic [W-1:0]  rt_ms_nxt, clamped;
   logic          stim_led_nxt, rt_valid_nxt, false_start_nxt, timeout_nxt;
   logic          rng_enable_nxt, busy_nxt, tick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         prescaler   <= '0;
         delay_cnt   <= '0;
         rt_cnt      <= '0;
         rng_enable  <= 1'b1;
         stim_led    <= 1'b0;
         rt_ms       <= '0;
         rt_valid    <= 1'b0;
         false_start <= 1'b0;
         timeout     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         prescaler   <= prescaler_nxt;
         delay_cnt   <= delay_cnt_nxt;
         rt_cnt      <= rt_cnt_nxt;
         rng_enable  <= rng_enable_nxt;
         stim_led    <= stim_led_nxt;
         rt_ms       <= rt_ms_nxt;
         rt_valid    <= rt_valid_nxt;
         false_start <= false_start_nxt;
         timeout     <= timeout_nxt;
         busy        <= busy_nxt;
      end
   end

   always_comb begin
      if (rnd_in < MIN_D) begin
         clamped = MIN_D;
      end else if (rnd_in > MAX_D) begin
         clamped = MAX_D;
      end else begin
         clamped = rnd_in;
      end
   end

   // Button checks come before tick handling so a press always takes priority.
   always_comb begin
      state_nxt       = state;
      prescaler_nxt   = prescaler;
      delay_cnt_nxt   = delay_cnt;
      rt_cnt_nxt      = rt_cnt;
      stim_led_nxt    = stim_led;
      rt_ms_nxt       = rt_ms;
      rt_valid_nxt    = 1'b0;
      false_start_nxt = false_start;
      timeout_nxt     = timeout;
      tick            = (prescaler == PRESC_LAST);
      prescaler_adv   = tick ? '0 : prescaler + 1'b1;
      rt_inc          = rt_cnt + 1'b1;

      case (state)
         IDLE, DONE, FAULT: begin
            if (start) begin
               state_nxt       = WAIT;
               delay_cnt_nxt   = clamped;
               prescaler_nxt   = '0;
               false_start_nxt = 1'b0;
               timeout_nxt     = 1'b0;
            end
         end
         WAIT: begin
            prescaler_nxt = prescaler_adv;
            if (button) begin
               state_nxt       = FAULT;
               false_start_nxt = 1'b1;
               prescaler_nxt   = '0;
            end else if (tick) begin
               if (delay_cnt == 1) begin
                  state_nxt     = REACT;
                  stim_led_nxt  = 1'b1;
                  rt_cnt_nxt    = '0;
                  prescaler_nxt = '0;
               end else begin
                  delay_cnt_nxt = delay_cnt - 1'b1;
               end
            end
         end
         REACT: begin
            prescaler_nxt = prescaler_adv;
            if (button) begin
               state_nxt     = DONE;
               stim_led_nxt  = 1'b0;
               rt_ms_nxt     = tick ? rt_inc : rt_cnt;
               rt_valid_nxt  = 1'b1;
               prescaler_nxt = '0;
            end else if (tick) begin
               if (rt_inc == TIMEOUT_V) begin
                  state_nxt     = DONE;
                  timeout_nxt   = 1'b1;
                  rt_ms_nxt     = TIMEOUT_V;
                  rt_valid_nxt  = 1'b1;
                  stim_led_nxt  = 1'b0;
                  prescaler_nxt = '0;
               end else begin
                  rt_cnt_nxt = rt_inc;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt       = (state_nxt == WAIT) || (state_nxt == REACT);
      rng_enable_nxt = !busy_nxt;
   end

endmodule

// File: tb/tb_reaction_sequencer.sv
// Directed bench for reaction_sequencer: table of full trials plus hand-written
// false-start, timeout, collision and async-reset sequences.
module tb_reaction_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start, button;
   logic [13:0] rnd_in;
   logic        rng_enable, stim_led, rt_valid, false_start, timeout, busy;
   logic [13:0] rt_ms;

   logic        start_b, button_b;
   logic [13:0] rnd_in_b;
   logic        rng_enable_b, stim_led_b, rt_valid_b, false_start_b, timeout_b, busy_b;
   logic [13:0] rt_ms_b;

   int test_count = 0;
   int fail_count = 0;

   reaction_sequencer #(
      .TICKS_PER_MS(4), .MIN_DELAY_MS(1000), .MAX_DELAY_MS(5000),
      .TIMEOUT_MS(9999), .W(14)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .button(button), .rnd_in(rnd_in),
      .rng_enable(rng_enable), .stim_led(stim_led), .rt_ms(rt_ms), .rt_valid(rt_valid),
      .false_start(false_start), .timeout(timeout), .busy(busy)
   );

   // Short-delay, short-timeout instance for the cycle-exact collision cases.
   reaction_sequencer #(
      .TICKS_PER_MS(4), .MIN_DELAY_MS(2), .MAX_DELAY_MS(5),
      .TIMEOUT_MS(20), .W(14)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .button(button_b), .rnd_in(rnd_in_b),
      .rng_enable(rng_enable_b), .stim_led(stim_led_b), .rt_ms(rt_ms_b), .rt_valid(rt_valid_b),
      .false_start(false_start_b), .timeout(timeout_b), .busy(busy_b)
   );

   typedef struct {
      logic [13:0] rnd;
      int          press_cycles;
      int          exp_stim;
      int          exp_rt;
   } trial_t;

   trial_t trials[3];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic b, input logic [13:0] r);
      start  = s;
      button = b;
      rnd_in = r;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic runTrial(input trial_t t);
      int cnt;
      int bad;
      bad = 0;
      applyStimulus(1'b1, 1'b0, t.rnd);
      stepCycle();
      applyStimulus(1'b0, 1'b0, t.rnd);
      checkOutput("trial_busy_wait", busy, 1);
      checkOutput("trial_false_start_clear", false_start, 0);
      cnt = 0;
      while (!stim_led && cnt < 30000) begin
         stepCycle();
         cnt++;
         if (rng_enable) bad++;
      end
      checkOutput("trial_stim_delay", cnt, t.exp_stim);
      repeat (t.press_cycles) begin
         stepCycle();
         if (rng_enable || !stim_led) bad++;
      end
      button = 1'b1;
      stepCycle();
      checkOutput("trial_rt_ms", rt_ms, t.exp_rt);
      checkOutput("trial_rt_valid", rt_valid, 1);
      checkOutput("trial_stim_off", stim_led, 0);
      button = 1'b0;
      stepCycle();
      checkOutput("trial_rt_valid_once", rt_valid, 0);
      checkOutput("trial_rng_enable_done", rng_enable, 1);
      checkOutput("trial_rt_hold", rt_ms, t.exp_rt);
      checkOutput("trial_rng_low_while_busy", bad, 0);
   endtask

   initial begin
      int cnt;
      int bad;

      trials[0] = '{rnd: 14'd1200, press_cycles: 200, exp_stim: 4800,  exp_rt: 50};
      trials[1] = '{rnd: 14'd300,  press_cycles: 10,  exp_stim: 4000,  exp_rt: 2};
      trials[2] = '{rnd: 14'd9000, press_cycles: 3,   exp_stim: 20000, exp_rt: 1};

      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 14'd0);
      start_b = 1'b0; button_b = 1'b0; rnd_in_b = 14'd0;
      #12;
      checkOutput("reset_rng_enable", rng_enable, 1);
      checkOutput("reset_stim", stim_led, 0);
      checkOutput("reset_rt_ms", rt_ms, 0);
      checkOutput("reset_flags", {rt_valid, false_start, timeout, busy}, 0);
      @(negedge clk);
      reset = 1'b1;
      stepCycle();
      checkOutput("idle_after_release", {rng_enable, busy}, 2'b10);

      // False start 500 ms into WAIT.
      applyStimulus(1'b1, 1'b0, 14'd1200);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 14'd1200);
      bad = 0;
      repeat (2000) begin
         stepCycle();
         if (stim_led) bad++;
      end
      button = 1'b1;
      stepCycle();
      checkOutput("fs_flag", false_start, 1);
      checkOutput("fs_stim_never", bad + stim_led, 0);
      checkOutput("fs_idle_outputs", {busy, rng_enable, rt_valid}, 3'b010);
      checkOutput("fs_rt_unchanged", rt_ms, 0);
      button = 1'b0;
      repeat (3) stepCycle();
      checkOutput("fs_sticky", {false_start, rt_valid}, 2'b10);

      // Button held while start is accepted faults two cycles later.
      applyStimulus(1'b1, 1'b1, 14'd1200);
      stepCycle();
      applyStimulus(1'b0, 1'b1, 14'd1200);
      checkOutput("held_first_wait", {busy, false_start}, 2'b10);
      stepCycle();
      checkOutput("held_fault", {busy, false_start}, 2'b01);
      button = 1'b0;
      stepCycle();

      for (int i = 0; i < 3; i++) begin
         runTrial(trials[i]);
      end

      // Full timeout, with ignored start pulses in WAIT and REACT.
      applyStimulus(1'b1, 1'b0, 14'd300);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 14'd300);
      cnt = 0;
      while (!stim_led && cnt < 30000) begin
         stepCycle();
         cnt++;
         start = (cnt == 100);
      end
      checkOutput("to_stim_delay", cnt, 4000);
      cnt = 0;
      bad = 0;
      while (!rt_valid && cnt < 50000) begin
         stepCycle();
         cnt++;
         start = (cnt == 5);
         if (!rt_valid && !stim_led) bad++;
      end
      start = 1'b0;
      checkOutput("to_cycles", cnt, 39996);
      checkOutput("to_stim_during_react", bad, 0);
      checkOutput("to_flag", timeout, 1);
      checkOutput("to_rt_ms", rt_ms, 9999);
      checkOutput("to_stim_off", stim_led, 0);
      stepCycle();
      checkOutput("to_rt_valid_once", rt_valid, 0);
      checkOutput("to_done_hold", {timeout, rng_enable, busy}, 3'b110);

      // Button on the final WAIT tick: false start wins.
      rnd_in_b = 14'd3;
      start_b = 1'b1;
      stepCycle();
      start_b = 1'b0;
      repeat (11) stepCycle();
      button_b = 1'b1;
      stepCycle();
      checkOutput("coll_wait_fault", {false_start_b, stim_led_b, busy_b}, 3'b100);
      button_b = 1'b0;

      // Button on the timeout tick, one cycle before it, then no button at all.
      for (int k = 0; k < 3; k++) begin
         rnd_in_b = 14'd0;
         start_b = 1'b1;
         stepCycle();
         start_b = 1'b0;
         cnt = 0;
         while (!stim_led_b && cnt < 100) begin
            stepCycle();
            cnt++;
         end
         checkOutput("b_stim_delay_min_clamp", cnt, 8);
         if (k < 2) begin
            repeat (79 - k) stepCycle();
            button_b = 1'b1;
            stepCycle();
            button_b = 1'b0;
            checkOutput("b_press_rt_ms", rt_ms_b, 20 - k);
            checkOutput("b_press_flags", {rt_valid_b, timeout_b, stim_led_b}, 3'b100);
         end else begin
            cnt = 0;
            while (!rt_valid_b && cnt < 200) begin
               stepCycle();
               cnt++;
            end
            checkOutput("b_timeout_cycles", cnt, 80);
            checkOutput("b_timeout_flags", {timeout_b, rt_ms_b}, {1'b1, 14'd20});
         end
         stepCycle();
      end

      // Async reset in the middle of a REACT phase.
      rnd_in_b = 14'd4;
      start_b = 1'b1;
      stepCycle();
      start_b = 1'b0;
      cnt = 0;
      while (!stim_led_b && cnt < 100) begin
         stepCycle();
         cnt++;
      end
      checkOutput("rst_stim_delay", cnt, 16);
      repeat (5) stepCycle();
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rst_async_stim", stim_led_b, 0);
      checkOutput("rst_async_flags", {busy_b, false_start_b, timeout_b, rt_valid_b}, 0);
      checkOutput("rst_async_rt_ms", rt_ms_b, 0);
      checkOutput("rst_async_rng", rng_enable_b, 1);
      checkOutput("rst_async_main", {timeout, rt_ms}, 0);
      @(negedge clk);
      reset = 1'b1;
      stepCycle();
      checkOutput("rst_release_idle", {rng_enable_b, busy_b, stim_led_b}, 3'b100);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/reaction_sequencer.md
Name: reaction_sequencer

Overview:
Consumes the 14-bit pseudo-random wait time (ms) from the RNG. Runs one reaction-time trial per start request:
- waits the random delay;
- lights the stimulus LED;
- measures the button reaction in ms.

Also drives the RNG enable and flags false starts and timeouts. It sits between the RNG/button-conditioning logic and the display/score logic.

Parameters:
TICKS_PER_MS, 100000, clk cycles per 1 ms tick (100 MHz clk); benches use 4
MIN_DELAY_MS, 1000, lower clamp applied to latched random delay
MAX_DELAY_MS, 5000, upper clamp applied to latched random delay
TIMEOUT_MS, 9999, reaction count at which the trial aborts
W, 14, width of delay and reaction-time values

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
start  in  1  synchronous single-cycle request to begin a trial
button  in  1  debounced, synchronised button level, 1 = pressed
rnd_in  in  W  current random value from RNG, ms
rng_enable  out  1  RNG advance enable
stim_led  out  1  stimulus indicator
rt_ms  out  W  last measured reaction time, ms
rt_valid  out  1  one-cycle pulse when rt_ms updates
false_start  out  1  sticky: button pressed before stimulus
timeout  out  1  sticky: no press within TIMEOUT_MS
busy  out  1  high in WAIT or REACT

Behaviour:
- Reset (reset=0, async) forces the following:
  - state=IDLE, rng_enable=1, stim_led=0;
  - rt_ms=0, rt_valid=0, false_start=0, timeout=0, busy=0;
  - internal prescaler, delay and reaction counters=0.
- States: IDLE, WAIT, REACT, DONE, FAULT. All outputs are registered.
- rng_enable=1 in IDLE, DONE and FAULT, and 0 in WAIT and REACT. The RNG free-runs between trials.
- start accepted in IDLE, DONE or FAULT (cycle N):
  - delay_cnt <= clamp(rnd_in, MIN_DELAY_MS, MAX_DELAY_MS);
  - prescaler <= 0;
  - false_start, timeout <= 0;
  - state <= WAIT at N+1.
  - rt_ms holds its previous value.
- start in WAIT or REACT is ignored.
- Prescaler counts 0..TICKS_PER_MS-1 and wraps. The wrap cycle is the ms tick. It runs only in WAIT and REACT, and is cleared on every state entry.
- WAIT:
  - on each tick, delay_cnt decrements;
  - tick with delay_cnt==1 -> REACT, stim_led<=1, rt counter<=0. stim_led therefore rises exactly D*TICKS_PER_MS cycles after WAIT entry (D = clamped delay).
  - button=1 on any WAIT cycle -> FAULT, false_start<=1, stim_led stays 0.
  - button sampled on the first WAIT cycle, so a button held at start faults at N+2.
- REACT:
  - on each tick, rt counter increments;
  - button=1 -> DONE, stim_led<=0, rt_ms<=rt counter, rt_valid=1 for exactly one cycle;
  - tick taking rt counter to TIMEOUT_MS -> DONE, timeout<=1, rt_ms<=TIMEOUT_MS, rt_valid pulse, stim_led<=0.
- DONE and FAULT hold all outputs until the next accepted start. FAULT leaves rt_ms unchanged and pulses no rt_valid.
- Simultaneous events:
  - WAIT expiry tick and button in the same cycle -> FAULT (false start wins);
  - REACT timeout tick and button in the same cycle -> button wins, rt_ms = incremented count, timeout=0;
  - start and button both high in DONE -> start accepted, and the button is evaluated from the first WAIT cycle.
- Arithmetic: counters are W bits and never wrap; the TIMEOUT_MS and clamp bounds guarantee this. Clamp is unsigned.
- Reset asserted mid-trial returns to reset values immediately, with stim_led dropping asynchronously.

Test Plan:
1. TICKS_PER_MS=4, rnd_in=1200, start at cycle 10, button pressed 50 ticks (200 cycles) after stim_led rises -> stim_led rises 4800 cycles after WAIT entry; rt_ms=50; one rt_valid pulse; rng_enable low throughout WAIT/REACT.
2. Clamping: rnd_in=300 -> stim_led after 1000 ms (4000 cycles); rnd_in=9000 -> stim_led after 5000 ms (20000 cycles).
3. False start: button=1 at 500 ms into WAIT -> FAULT next cycle; false_start=1; stim_led never rises; rt_ms unchanged; no rt_valid. Then start with button=0 -> false_start clears and a normal trial completes.
4. Timeout: no button after stimulus -> after 9999 ticks: timeout=1, rt_ms=9999, one rt_valid pulse, DONE. Also button on the exact timeout tick -> rt_ms=9999, timeout=0.
5. Edge collisions: button on the WAIT expiry cycle -> FAULT. start pulses during WAIT and REACT -> no effect on timing.
6. Async reset: reset=0 mid-REACT, between clock edges -> stim_led=0, busy=0 and all flags 0 immediately; IDLE with rng_enable=1 after release.
